// File: rtl/fifo_burst_reader.sv
// Drains a synchronous FIFO into a registered valid/ready stream framed as fixed-length
// bursts, with a short flush burst when residual data sits idle for too long.
module fifo_burst_reader #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 4,
   parameter int BURST_LEN = 4,
   parameter int TIMEOUT   = 15,
   parameter int TIMER_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              fifo_rd_en,
   input  logic [DATA_W-1:0] fifo_rd_data,
   input  logic              fifo_empty,
   input  logic [ADDR_W:0]   fifo_word_count,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic              burst_done,
   output logic              short_burst,
   output logic [1:0]        fsm_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam logic [ADDR_W:0]    BURST_CNT = (ADDR_W+1)'(BURST_LEN);
   localparam logic [ADDR_W:0]    ONE_BEAT  = (ADDR_W+1)'(1);
   localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT);

   state_t             state;
   logic [TIMER_W-1:0] timer;
   logic [ADDR_W:0]    beats_left;
   logic               out_free;
   logic               popping;

   // The output register may be refilled in the same cycle its word is accepted.
   assign out_free    = !m_valid || m_ready;
   assign popping     = (state == BURST || state == FLUSH) && !fifo_empty && out_free;
   assign fifo_rd_en  = rst_n && popping;
   assign short_burst = (state == FLUSH);
   assign fsm_state   = state;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         timer      <= '0;
         beats_left <= '0;
         m_valid    <= 1'b0;
         m_data     <= '0;
         m_last     <= 1'b0;
         burst_done <= 1'b0;
      end else begin
         burst_done <= m_valid && m_ready && m_last;

         if (popping) begin
            m_data     <= fifo_rd_data;
            m_valid    <= 1'b1;
            m_last     <= (beats_left == ONE_BEAT);
            beats_left <= beats_left - ONE_BEAT;
         end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (fifo_word_count >= BURST_CNT) begin
                  state      <= BURST;
                  beats_left <= BURST_CNT;
                  timer      <= '0;
               end else if (!fifo_empty && timer == TIMER_MAX) begin
                  // Occupancy is below a full burst here, so the snapshot is the flush length.
                  state      <= FLUSH;
                  beats_left <= fifo_word_count;
                  timer      <= '0;
               end else if (!fifo_empty) begin
                  timer <= timer + TIMER_W'(1);
               end else begin
                  timer <= '0;
               end
            end
            BURST, FLUSH: begin
               timer <= '0;
               if (popping && beats_left == ONE_BEAT) state <= IDLE;
            end
            default: begin
               state <= IDLE;
               timer <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: behavioural FIFOs feed a BURST_LEN=4 and a
// BURST_LEN=1 instance; accepted beats are scored against an expected queue.
module tb_fifo_burst_reader;

   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // FIFO 0 feeds the BURST_LEN=4 instance, FIFO 1 the BURST_LEN=1 instance.
   logic          wr_en0 = 1'b0, wr_en1 = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic [DW-1:0] mem0 [16];
   logic [DW-1:0] mem1 [16];
   logic [3:0]    wp0 = '0, rp0 = '0, wp1 = '0, rp1 = '0;
   logic [4:0]    cnt0 = '0, cnt1 = '0;

   logic          rd_en0, rd_en1;
   logic [DW-1:0] rd_data0, rd_data1;
   logic          empty0, empty1;

   assign rd_data0 = mem0[rp0];
   assign rd_data1 = mem1[rp1];
   assign empty0   = (cnt0 == 5'd0);
   assign empty1   = (cnt1 == 5'd0);

   always @(posedge clk) begin
      if (wr_en0) begin mem0[wp0] <= wr_data; wp0 <= wp0 + 4'd1; end
      if (rd_en0) rp0 <= rp0 + 4'd1;
      cnt0 <= cnt0 + {4'd0, wr_en0} - {4'd0, rd_en0};
      if (wr_en1) begin mem1[wp1] <= wr_data; wp1 <= wp1 + 4'd1; end
      if (rd_en1) rp1 <= rp1 + 4'd1;
      cnt1 <= cnt1 + {4'd0, wr_en1} - {4'd0, rd_en1};
   end

   logic          m_valid, m_last, burst_done, short_burst;
   logic          m_ready = 1'b1;
   logic [DW-1:0] m_data;
   logic [1:0]    fsm_state;

   logic          m1_valid, m1_last, burst_done1, short_burst1;
   logic          m1_ready = 1'b1;
   logic [DW-1:0] m1_data;
   logic [1:0]    fsm_state1;

   fifo_burst_reader #(.DATA_W(DW), .ADDR_W(4), .BURST_LEN(4), .TIMEOUT(15), .TIMER_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .fifo_rd_en(rd_en0), .fifo_rd_data(rd_data0), .fifo_empty(empty0), .fifo_word_count(cnt0),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .burst_done(burst_done), .short_burst(short_burst), .fsm_state(fsm_state)
   );

   fifo_burst_reader #(.DATA_W(DW), .ADDR_W(4), .BURST_LEN(1), .TIMEOUT(15), .TIMER_W(8)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .fifo_rd_en(rd_en1), .fifo_rd_data(rd_data1), .fifo_empty(empty1), .fifo_word_count(cnt1),
      .m_valid(m1_valid), .m_ready(m1_ready), .m_data(m1_data), .m_last(m1_last),
      .burst_done(burst_done1), .short_burst(short_burst1), .fsm_state(fsm_state1)
   );

   // Scoreboard entries are {m_last, m_data}.
   logic [DW:0] exp_q [$];
   logic [DW:0] exp1_q [$];

   int tests = 0, fails = 0;
   int pops = 0, short_pops = 0, bd_cnt = 0, bd1_cnt = 0, beats0 = 0;
   bit toggle = 1'b0;
   bit hold_pending = 1'b0;
   logic [DW:0] hold_word;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs are stable here until the coming edge, so this sees exactly what the DUT samples.
   task automatic cycle();
      logic [DW:0] e;
      if (rd_en0) begin pops++; if (short_burst) short_pops++; end
      if (burst_done)  bd_cnt++;
      if (burst_done1) bd1_cnt++;
      if (hold_pending && m_valid) check("hold_word", {23'd0, m_last, m_data}, {23'd0, hold_word});
      hold_pending = m_valid && !m_ready;
      hold_word    = {m_last, m_data};
      if (m_valid && m_ready) begin
         beats0++;
         if (exp_q.size() == 0) check("unexpected_beat", {23'd0, m_last, m_data}, 32'hFFFF_FFFF);
         else begin e = exp_q.pop_front(); check("beat", {23'd0, m_last, m_data}, {23'd0, e}); end
      end
      if (m1_valid && m1_ready) begin
         if (exp1_q.size() == 0) check("unexpected_beat1", {23'd0, m1_last, m1_data}, 32'hFFFF_FFFF);
         else begin e = exp1_q.pop_front(); check("beat1", {23'd0, m1_last, m1_data}, {23'd0, e}); end
      end
      @(posedge clk);
      @(negedge clk);
      if (toggle) m_ready = ~m_ready;
   endtask

   task automatic write0(input logic [DW-1:0] d, input bit push, input bit last);
      wr_en0  = 1'b1;
      wr_data = d;
      if (push) exp_q.push_back({last, d});
      cycle();
      wr_en0 = 1'b0;
   endtask

   task automatic write1(input logic [DW-1:0] d);
      wr_en1  = 1'b1;
      wr_data = d;
      exp1_q.push_back({1'b1, d});
      cycle();
      wr_en1 = 1'b0;
   endtask

   task automatic drain(input string tag);
      int guard = 0;
      while ((exp_q.size() != 0 || exp1_q.size() != 0) && guard < 200) begin
         cycle();
         guard++;
      end
      check({tag, "_drain_left"}, exp_q.size() + exp1_q.size(), 0);
      repeat (3) cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0, sp0, b0, idle_cnt, start;
      logic [DW-1:0] c [4];

      // Reset state
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) cycle();
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_m_last", m_last, 0);
      check("rst_burst_done", burst_done, 0);
      check("rst_rd_en", rd_en0, 0);
      check("rst_state", fsm_state, 0);
      rst_n = 1'b1;
      cycle();

      // Full burst of 4
      b0 = bd_cnt; p0 = pops; sp0 = short_pops;
      for (int i = 0; i < 4; i++) write0(DW'($urandom_range(0, 255)), 1'b1, i == 3);
      drain("t1");
      check("t1_burst_done", bd_cnt - b0, 1);
      check("t1_pops", pops - p0, 4);
      check("t1_short", short_pops - sp0, 0);
      check("t1_empty", empty0, 1);

      // Two residual words are flushed after the timeout
      b0 = bd_cnt; p0 = pops; sp0 = short_pops;
      write0(8'hB0, 1'b1, 1'b0);
      write0(8'hB1, 1'b1, 1'b1);
      idle_cnt = 0;
      while (!rd_en0 && idle_cnt < 100) begin cycle(); idle_cnt++; end
      check("t2_idle_cycles", idle_cnt, 15);
      check("t2_short_flag", short_burst, 1);
      drain("t2");
      check("t2_short_pops", short_pops - sp0, 2);
      check("t2_pops", pops - p0, 2);
      check("t2_burst_done", bd_cnt - b0, 1);
      check("t2_short_after", short_burst, 0);

      // Sixteen words with m_ready toggling every cycle
      b0 = bd_cnt;
      toggle = 1'b1;
      for (int i = 0; i < 16; i++) write0(DW'($urandom_range(0, 255)), 1'b1, (i % 4) == 3);
      drain("t3");
      toggle  = 1'b0;
      m_ready = 1'b1;
      repeat (2) cycle();
      check("t3_burst_done", bd_cnt - b0, 4);
      check("t3_empty", empty0, 1);

      // Fourth word arrives well before the timeout: full burst, not a flush
      b0 = bd_cnt; p0 = pops; sp0 = short_pops;
      for (int i = 0; i < 3; i++) write0(DW'($urandom_range(0, 255)), 1'b1, 1'b0);
      repeat (7) cycle();
      write0(DW'($urandom_range(0, 255)), 1'b1, 1'b1);
      drain("t4");
      check("t4_pops", pops - p0, 4);
      check("t4_short", short_pops - sp0, 0);
      check("t4_burst_done", bd_cnt - b0, 1);

      // Reset while the second beat is stalled; the other two words flush later
      for (int i = 0; i < 4; i++) c[i] = DW'(8'h40 + i);
      write0(c[0], 1'b1, 1'b0);
      write0(c[1], 1'b0, 1'b0);
      write0(c[2], 1'b1, 1'b0);
      write0(c[3], 1'b1, 1'b1);
      start = beats0;
      idle_cnt = 0;
      while (beats0 == start && idle_cnt < 50) begin cycle(); idle_cnt++; end
      check("t5_first_beat_seen", beats0 - start, 1);
      m_ready = 1'b0;
      check("t5_held_valid", m_valid, 1);
      check("t5_held_data", m_data, c[1]);
      rst_n = 1'b0;
      cycle();
      check("t5_rst_valid", m_valid, 0);
      check("t5_rst_last", m_last, 0);
      check("t5_rst_state", fsm_state, 0);
      check("t5_fifo_kept", cnt0, 2);
      rst_n   = 1'b1;
      m_ready = 1'b1;
      p0 = pops; sp0 = short_pops;
      drain("t5");
      check("t5_short_pops", short_pops - sp0, 2);
      check("t5_pops", pops - p0, 2);

      // Single-beat bursts
      b0 = bd1_cnt;
      for (int i = 0; i < 3; i++) write1(DW'($urandom_range(0, 255)));
      drain("t6");
      check("t6_burst_done", bd1_cnt - b0, 3);
      check("t6_empty", empty1, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
